// File: rtl/fp_multiplier_seq_if.sv
// Purpose: start/busy/done handshake and operand/result bus of the
//          sequential single-precision multiplier.
// Signals:
//   start     requester -> multiplier, sampled only while busy==0
//   a, b      requester -> multiplier, operands captured with start
//   busy      multiplier -> requester, operation in flight
//   done      multiplier -> requester, one-cycle pulse, result/flags valid
//   result    multiplier -> requester, product, held until next accepted start
//   overflow  multiplier -> requester, exponent overflow, held with result
//   underflow multiplier -> requester, exponent underflow, held with result
interface fp_multiplier_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  modport master (
    output start, a, b,
    input  busy, done, result, overflow, underflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, overflow, underflow
  );
endinterface

// File: rtl/fp_multiplier_seq.sv
// Purpose: multi-cycle IEEE-754 single-precision multiplier. A shift-add
//          engine consumes BITS_PER_CYCLE multiplier bits per clock; the
//          product is truncated (no rounding) and denormal inputs are
//          flushed to zero.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, aborts any operation
//   bus    fp_multiplier_seq_if.slave (start, a, b, busy, done, result,
//          overflow, underflow)
//
// state | meaning
// IDLE  | waiting for start; also the cycle after done, where busy drops
// CALC  | classify operands; special result, or first partial product
// MUL   | remaining shift-add iterations
// NORM  | normalise, range check, write result
module fp_multiplier_seq #(
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] QNAN_VALUE     = 32'h7FC00000
) (
  input  logic              clk,
  input  logic              reset,
  fp_multiplier_seq_if.slave bus
);

  localparam int ITER = 24 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, CALC, MUL, NORM} state_t;

  state_t             state;
  logic [31:0]        op_a, op_b;
  logic [23:0]        mcand, mplier;
  logic [47:0]        acc;
  logic signed [9:0]  exp_sum;
  logic [4:0]         cnt;
  logic               sign;
  logic               busy_r, done_r, ovf_r, unf_r;
  logic [31:0]        result_r;

  logic [7:0]                ea, eb;
  logic [22:0]               fa, fb;
  logic                      nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [47:0]               pp, acc_next;
  logic signed [9:0]         exp_n;
  logic [22:0]               frac_n;

  always_comb begin
    ea     = op_a[30:23];
    eb     = op_b[30:23];
    fa     = op_a[22:0];
    fb     = op_b[22:0];
    nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    nan_b  = (eb == 8'hFF) && (fb != 23'd0);
    inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    zero_a = (ea == 8'h00);
    zero_b = (eb == 8'h00);
    // Multiplier is consumed MSB-first, so the accumulator shifts left.
    digit    = mplier[23 -: BITS_PER_CYCLE];
    pp       = 48'(mcand) * 48'(digit);
    acc_next = (acc << BITS_PER_CYCLE) + pp;
    exp_n    = acc[47] ? exp_sum + 10'sd1 : exp_sum;
    frac_n   = acc[47] ? acc[46:24] : acc[45:23];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      exp_sum  <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          // busy is still high in the cycle after done, which blocks a start
          // presented during the done cycle.
          if (bus.start && !busy_r) begin
            op_a   <= bus.a;
            op_b   <= bus.b;
            mcand  <= {1'b1, bus.a[22:0]};
            mplier <= {1'b1, bus.b[22:0]};
            acc    <= '0;
            sign   <= bus.a[31] ^ bus.b[31];
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            busy_r <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          exp_sum <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
          if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            result_r <= QNAN_VALUE;
            done_r   <= 1'b1;
            state    <= IDLE;
          end else if (inf_a || inf_b) begin
            result_r <= {sign, 8'hFF, 23'd0};
            done_r   <= 1'b1;
            state    <= IDLE;
          end else if (zero_a || zero_b) begin
            result_r <= {sign, 31'd0};
            done_r   <= 1'b1;
            state    <= IDLE;
          end else begin
            acc    <= acc_next;
            mplier <= mplier << BITS_PER_CYCLE;
            cnt    <= 5'(ITER - 1);
            state  <= (ITER == 1) ? NORM : MUL;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mplier <= mplier << BITS_PER_CYCLE;
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd1) state <= NORM;
        end
        NORM: begin
          if (exp_n >= 10'sd255) begin
            result_r <= {sign, 8'hFF, 23'd0};
            ovf_r    <= 1'b1;
          end else if (exp_n <= 10'sd0) begin
            result_r <= {sign, 31'd0};
            unf_r    <= 1'b1;
          end else begin
            result_r <= {sign, exp_n[7:0], frac_n};
          end
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
module tb_fp_multiplier_seq;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_multiplier_seq_if if1();
  fp_multiplier_seq_if if4();

  fp_multiplier_seq #(.BITS_PER_CYCLE(1), .QNAN_VALUE(QNAN)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  fp_multiplier_seq #(.BITS_PER_CYCLE(4), .QNAN_VALUE(QNAN)) dut4 (
    .clk(clk), .reset(reset), .bus(if4.slave));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (sel == 4) begin
      if4.start = s; if4.a = a; if4.b = b;
    end else begin
      if1.start = s; if1.a = a; if1.b = b;
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 4) ? if4.done : if1.done;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 4) ? if4.busy : if1.busy;
  endfunction
  function automatic logic [31:0] get_result(input int sel);
    return (sel == 4) ? if4.result : if1.result;
  endfunction
  function automatic logic [31:0] get_flags(input int sel);
    return (sel == 4) ? {30'd0, if4.overflow, if4.underflow}
                      : {30'd0, if1.overflow, if1.underflow};
  endfunction

  // Reference: plain arithmetic on the IEEE fields, full 48-bit product.
  task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [31:0] flags,
                         output bit special);
    int ea, eb, e;
    longint ma, mb, p, frac;
    logic s;
    bit nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    z_a = (ea == 0);
    z_b = (eb == 0);
    flags = 32'd0;
    special = 1'b1;
    if (nan_a || nan_b || (inf_a && z_b) || (z_a && inf_b)) r = QNAN;
    else if (inf_a || inf_b) r = {s, 8'hFF, 23'd0};
    else if (z_a || z_b) r = {s, 31'd0};
    else begin
      special = 1'b0;
      ma = 64'h800000 + longint'(a[22:0]);
      mb = 64'h800000 + longint'(b[22:0]);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        frac = (p >> 24) & 64'h7FFFFF;
        e = e + 1;
      end else begin
        frac = (p >> 23) & 64'h7FFFFF;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        flags = 32'd2;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        flags = 32'd1;
      end else begin
        r = {s, 8'(e), 23'(frac)};
      end
    end
  endtask

  // Issues one operation, returns at the negedge where done is seen.
  // glitch_at > 0 presents a second start (other operands) while busy.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input int glitch_at, output logic [31:0] res,
                        output logic [31:0] flags, output int lat);
    @(negedge clk);
    drive(sel, 1'b1, a, b);
    @(negedge clk);
    drive(sel, 1'b0, 32'h0, 32'h0);
    check("busy_after_accept", {31'd0, get_busy(sel)}, 32'd1);
    lat = 0;
    while (lat < 40) begin
      if (glitch_at > 0 && lat == glitch_at) drive(sel, 1'b1, 32'h3F800000, 32'h40000000);
      else drive(sel, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      lat++;
      if (get_done(sel)) break;
    end
    drive(sel, 1'b0, 32'h0, 32'h0);
    res   = get_result(sel);
    flags = get_flags(sel);
    check("busy_in_done_cycle", {31'd0, get_busy(sel)}, 32'd1);
  endtask

  task automatic post_done(input int sel, input logic [31:0] held);
    @(negedge clk);
    check("done_one_cycle", {31'd0, get_done(sel)}, 32'd0);
    check("busy_dropped", {31'd0, get_busy(sel)}, 32'd0);
    check("result_held", get_result(sel), held);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] flags;
    int          lat;
  } vec_t;

  function automatic logic [31:0] gen_op();
    logic [7:0] e;
    int k;
    k = int'($urandom_range(0, 15));
    case (k)
      0:       e = 8'h00;
      1, 2:    e = 8'hFF;
      3:       e = 8'($urandom_range(200, 254));
      4:       e = 8'($urandom_range(1, 50));
      default: e = 8'($urandom_range(64, 190));
    endcase
    if (k == 1) return {1'($urandom), e, 23'd0};
    if (k == 2) return {1'($urandom), e, 23'($urandom) | 23'd1};
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    vec_t vecs[$];
    logic [31:0] res, flags, exp_r, exp_f;
    int lat;
    bit special;

    reset = 1'b1;
    drive(1, 1'b0, 32'h0, 32'h0);
    drive(4, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, if1.busy}, 32'd0);
    check("reset_done", {31'd0, if1.done}, 32'd0);
    check("reset_result", if1.result, 32'd0);
    check("reset_flags", get_flags(1), 32'd0);
    reset = 1'b0;

    vecs.push_back('{1, 32'h40400000, 32'h40200000, 32'h40F00000, 32'd0, 25});
    vecs.push_back('{1, 32'h7F000000, 32'h40000000, 32'h7F800000, 32'd2, 25});
    vecs.push_back('{1, 32'hC0000000, 32'h7F000000, 32'hFF800000, 32'd2, 25});
    vecs.push_back('{1, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'd0, 1});
    vecs.push_back('{1, 32'hC0000000, 32'h00000000, 32'h80000000, 32'd0, 1});
    vecs.push_back('{1, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'd0, 1});
    vecs.push_back('{1, 32'h00800000, 32'h00800000, 32'h00000000, 32'd1, 25});
    vecs.push_back('{1, 32'h3F800000, 32'hBF800000, 32'hBF800000, 32'd0, 25});
    vecs.push_back('{4, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'd0, 7});
    vecs.push_back('{4, 32'h40400000, 32'h40200000, 32'h40F00000, 32'd0, 7});

    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, 0, res, flags, lat);
      check($sformatf("dir%0d_result", i), res, vecs[i].r);
      check($sformatf("dir%0d_flags", i), flags, vecs[i].flags);
      check($sformatf("dir%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      post_done(vecs[i].sel, vecs[i].r);
    end

    // Start while busy must be ignored.
    run_op(1, 32'h40400000, 32'h40200000, 3, res, flags, lat);
    check("busy_start_result", res, 32'h40F00000);
    check("busy_start_latency", 32'(lat), 32'd25);
    post_done(1, 32'h40F00000);

    // Start held during the done cycle must be ignored too.
    run_op(1, 32'h3F800000, 32'hBF800000, 0, res, flags, lat);
    drive(1, 1'b1, 32'h40400000, 32'h40400000);
    @(negedge clk);
    check("done_cycle_start_busy", {31'd0, if1.busy}, 32'd0);
    check("done_cycle_start_result", if1.result, 32'hBF800000);
    drive(1, 1'b0, 32'h0, 32'h0);

    // Reset in the middle of an operation.
    @(negedge clk);
    drive(1, 1'b1, 32'h40400000, 32'h40200000);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midop_reset_busy", {31'd0, if1.busy}, 32'd0);
    check("midop_reset_done", {31'd0, if1.done}, 32'd0);
    check("midop_reset_result", if1.result, 32'd0);
    check("midop_reset_flags", get_flags(1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("after_reset_done", {31'd0, if1.done}, 32'd0);
    check("after_reset_result", if1.result, 32'd0);

    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [31:0] a, b;
      sel = (i % 2 == 1) ? 4 : 1;
      a = gen_op();
      b = gen_op();
      ref_mul(a, b, exp_r, exp_f, special);
      run_op(sel, a, b, 0, res, flags, lat);
      check($sformatf("rnd%0d_result a=%h b=%h", i, a, b), res, exp_r);
      check($sformatf("rnd%0d_flags", i), flags, exp_f);
      check($sformatf("rnd%0d_latency", i), 32'(lat),
            special ? 32'd1 : 32'(24 / sel + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
